icosoc_mod_extirq_multi: RTL and testbench

Multi-channel external interrupt controller, the parametrised successor to the single-pin external-IRQ module. It sits on the icosoc ctrl register bus as a peripheral. It monitors NUM_PINS pulled-up input pins through synchroniser, per-pin debounce and edge/level detection. It latches sticky pending bits, masks them with an enable register and drives a single ctrl_irq line to the CPU interrupt controller.

---
 rtl/icosoc_mod_extirq_multi.sv | 182 ++++++++++++++++++
 tb/tb_icosoc_mod_extirq_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icosoc_mod_extirq_multi.sv
// icosoc_mod_extirq_multi
//   Multi-channel external interrupt controller on the icosoc ctrl register bus.
//   Each pin is synchronised, debounced and checked against per-channel
//   hi/lo/rise/fall trigger selects. The selected conditions set sticky PENDING
//   bits. PENDING & ENABLE drives a single registered ctrl_irq.
//
//   Ports
//     clk        system clock, all logic on the rising edge
//     resetn     asynchronous active-low reset
//     ctrl_wr    register write request
//     ctrl_rd    register read request
//     ctrl_addr  register byte address
//     ctrl_wdat  write data
//     ctrl_rdat  registered read data, non-zero only while ctrl_done=1
//     ctrl_done  one-cycle access-complete pulse
//     ctrl_irq   registered level interrupt request
//     pins       package pins. The pad ring places a pulled-up SB_IO input
//                buffer on each pin, so the idle level is 1.
//
//   Register map
//     0x00 CONFIG  R/W, nibble i = {hi, lo, re, fe} for channel i
//     0x04 PENDING R, write-1-to-clear
//     0x08 ENABLE  R/W
//     0x0C STATE   R, filtered pin levels
//     0x10 FILTER  R/W, debounce threshold in cycles
module icosoc_mod_extirq_multi #(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int NUM_PINS      = 4,
  parameter int FILTER_W      = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ctrl_wr,
  input  logic                ctrl_rd,
  input  logic [7:0]          ctrl_addr,
  input  logic [31:0]         ctrl_wdat,
  output logic [31:0]         ctrl_rdat,
  output logic                ctrl_done,
  output logic                ctrl_irq,
  input  logic [NUM_PINS-1:0] pins
);

  localparam int CFG_W = 4 * NUM_PINS;

  typedef enum logic [7:0] {
    REG_CONFIG  = 8'h00,
    REG_PENDING = 8'h04,
    REG_ENABLE  = 8'h08,
    REG_STATE   = 8'h0C,
    REG_FILTER  = 8'h10
  } reg_addr_e;

  logic [NUM_PINS-1:0] sync1_q, sync2_q;
  logic [NUM_PINS-1:0] filt_q, filt_d;
  logic [NUM_PINS-1:0] prev_q;
  logic [FILTER_W-1:0] cnt_q [NUM_PINS];
  logic [FILTER_W-1:0] cnt_d [NUM_PINS];

  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic [NUM_PINS-1:0] en_q, en_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;
  logic [FILTER_W-1:0] filter_q, filter_d;

  logic [31:0]         rdat_q, rdat_d;
  logic                done_q, done_d;
  logic                irq_q, irq_d;

  logic                access, wr_en, rd_en;
  logic [31:0]         rd_val;
  logic [NUM_PINS-1:0] w1c;
  logic [NUM_PINS-1:0] trig;

  logic                unused_bits;
  assign unused_bits = ^{ctrl_wdat, CLOCK_FREQ_HZ != 0};

  // Debounce: the counter measures how long sync has disagreed with filt.
  // It is compared before incrementing, so the level moves once the
  // disagreement has lasted FILTER+1 cycles. FILTER=0 therefore gives a
  // single cycle of delay. A FILTER write below the running count takes
  // effect on the next edge.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filter_q) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + FILTER_W'(1);
      end
    end
  end

  always_comb begin
    trig = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      trig[i] = (cfg_q[4*i+3] &  filt_q[i])
              | (cfg_q[4*i+2] & ~filt_q[i])
              | (cfg_q[4*i+1] &  filt_q[i] & ~prev_q[i])
              | (cfg_q[4*i]   & ~filt_q[i] &  prev_q[i]);
    end
  end

  // A new request is taken only while ctrl_done is low. A held request
  // therefore completes every other cycle.
  always_comb begin
    access   = (ctrl_wr | ctrl_rd) & ~done_q;
    wr_en    = access & ctrl_wr;
    rd_en    = access & ctrl_rd;
    rd_val   = '0;
    cfg_d    = cfg_q;
    en_d     = en_q;
    filter_d = filter_q;
    w1c      = '0;
    case (ctrl_addr)
      REG_CONFIG: begin
        rd_val[CFG_W-1:0] = cfg_q;
        if (wr_en) cfg_d = ctrl_wdat[CFG_W-1:0];
      end
      REG_PENDING: begin
        rd_val[NUM_PINS-1:0] = pend_q;
        if (wr_en) w1c = ctrl_wdat[NUM_PINS-1:0];
      end
      REG_ENABLE: begin
        rd_val[NUM_PINS-1:0] = en_q;
        if (wr_en) en_d = ctrl_wdat[NUM_PINS-1:0];
      end
      REG_STATE: begin
        rd_val[NUM_PINS-1:0] = filt_q;
      end
      REG_FILTER: begin
        rd_val[FILTER_W-1:0] = filter_q;
        if (wr_en) filter_d = ctrl_wdat[FILTER_W-1:0];
      end
      default: ;
    endcase
    done_d = access;
    rdat_d = rd_en ? rd_val : '0;
    // The OR of trig after the clear lets a same-cycle set win over W1C.
    pend_d = (pend_q & ~w1c) | trig;
    irq_d  = |(pend_q & en_q);
  end

  // The synchroniser, filt and prev reset to 1, which matches the
  // pulled-up idle level. This prevents a false edge when reset is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      filt_q   <= '1;
      prev_q   <= '1;
      for (int unsigned i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
      cfg_q    <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      filter_q <= '0;
      rdat_q   <= '0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      filter_q <= filter_d;
      rdat_q   <= rdat_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  assign ctrl_rdat = rdat_q;
  assign ctrl_done = done_q;
  assign ctrl_irq  = irq_q;

endmodule

// File: tb/tb_icosoc_mod_extirq_multi.sv
module tb_icosoc_mod_extirq_multi;
  localparam int NP = 4;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  logic          ctrl_wr   = 1'b0;
  logic          ctrl_rd   = 1'b0;
  logic [7:0]    ctrl_addr = '0;
  logic [31:0]   ctrl_wdat = '0;
  logic [31:0]   ctrl_rdat;
  logic          ctrl_done;
  logic          ctrl_irq;
  logic [NP-1:0] pins      = '1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icosoc_mod_extirq_multi #(
    .CLOCK_FREQ_HZ(12000000),
    .NUM_PINS(NP),
    .FILTER_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ctrl_wr(ctrl_wr),
    .ctrl_rd(ctrl_rd),
    .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat),
    .ctrl_rdat(ctrl_rdat),
    .ctrl_done(ctrl_done),
    .ctrl_irq(ctrl_irq),
    .pins(pins)
  );

  // Reference model. Each pin keeps a history of its sampled values.
  // Bit k is the pin k+1 edges ago. The synchronised value used at an
  // edge is history bit 1. The filtered level flips once the last FILTER+1
  // synchronised samples all disagree with it.
  logic [15:0]   m_cfg;
  logic [NP-1:0] m_en, m_pend, m_filt, m_prev;
  logic [7:0]    m_filter;
  logic          m_irq, m_done;
  logic [31:0]   m_rdat;
  logic [63:0]   m_hist [NP];

  function automatic logic [NP-1:0] m_trig();
    logic [NP-1:0] t;
    logic [3:0]    n;
    for (int i = 0; i < NP; i++) begin
      n    = m_cfg[4*i +: 4];
      t[i] = (n[3] && m_filt[i]) || (n[2] && !m_filt[i]) ||
             (n[1] && m_filt[i] && !m_prev[i]) ||
             (n[0] && !m_filt[i] && m_prev[i]);
    end
    return t;
  endfunction

  function automatic logic m_filt_next(int ch);
    logic all_differ = 1'b1;
    for (int k = 1; k <= int'(m_filter) + 1; k++)
      if (m_hist[ch][k] == m_filt[ch]) all_differ = 1'b0;
    return all_differ ? ~m_filt[ch] : m_filt[ch];
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    case (a)
      8'h00:   return {16'h0, m_cfg};
      8'h04:   return {28'h0, m_pend};
      8'h08:   return {28'h0, m_en};
      8'h0C:   return {28'h0, m_filt};
      8'h10:   return {24'h0, m_filter};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_wr_to(logic [7:0] a);
    return ctrl_wr && !m_done && ctrl_addr == a;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cfg <= '0; m_en <= '0; m_pend <= '0; m_filter <= '0;
      m_filt <= '1; m_prev <= '1;
      m_irq <= 1'b0; m_done <= 1'b0; m_rdat <= '0;
      for (int ch = 0; ch < NP; ch++) m_hist[ch] <= '1;
    end else begin
      if ((ctrl_wr || ctrl_rd) && !m_done) begin
        m_done <= 1'b1;
        m_rdat <= ctrl_rd ? m_read(ctrl_addr) : 32'h0;
      end else begin
        m_done <= 1'b0;
        m_rdat <= 32'h0;
      end
      m_irq  <= |(m_pend & m_en);
      m_pend <= (m_pend & ~(m_wr_to(8'h04) ? ctrl_wdat[NP-1:0] : '0)) | m_trig();
      if (m_wr_to(8'h00)) m_cfg    <= ctrl_wdat[15:0];
      if (m_wr_to(8'h08)) m_en     <= ctrl_wdat[NP-1:0];
      if (m_wr_to(8'h10)) m_filter <= ctrl_wdat[7:0];
      for (int ch = 0; ch < NP; ch++) begin
        m_filt[ch] <= m_filt_next(ch);
        m_hist[ch] <= {m_hist[ch][62:0], pins[ch]};
      end
      m_prev <= m_filt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("done_vs_model", {31'h0, ctrl_done}, {31'h0, m_done});
    check("rdat_vs_model", ctrl_rdat, m_rdat);
    check("irq_vs_model", {31'h0, ctrl_irq}, {31'h0, m_irq});
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    ctrl_wr = 1'b1; ctrl_addr = a; ctrl_wdat = d;
    tick();
    ctrl_wr = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    ctrl_rd = 1'b1; ctrl_addr = a;
    tick();
    d = ctrl_rdat;
    ctrl_rd = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          pulses;
    int          g;

    // Reset state and idle pins after release
    repeat (3) tick();
    check("rst_rdat", ctrl_rdat, 32'h0);
    check("rst_done", {31'h0, ctrl_done}, 32'h0);
    check("rst_irq", {31'h0, ctrl_irq}, 32'h0);
    resetn = 1'b1;
    tick();
    bus_read(8'h00, d); check("rst_config", d, 32'h0);
    bus_read(8'h10, d); check("rst_filter", d, 32'h0);
    bus_write(8'h00, 32'h2);
    bus_write(8'h08, 32'h1);
    repeat (100) begin
      tick();
      check("idle_irq", {31'h0, ctrl_irq}, 32'h0);
    end
    bus_read(8'h04, d); check("idle_pending", d, 32'h0);
    bus_read(8'h0C, d); check("idle_state", d, 32'hF);

    // Rising edge on channel 0 with FILTER=0, then W1C
    pins[0] = 1'b0;
    repeat (10) tick();
    bus_read(8'h04, d); check("re_no_pend_on_fall", d, 32'h0);
    pins[0] = 1'b1;
    n = 0;
    while (ctrl_irq !== 1'b1 && n < 10) begin tick(); n++; end
    check("re_irq_latency", n, 5);
    bus_read(8'h04, d); check("re_pending", d, 32'h1);
    bus_write(8'h04, 32'h1);
    tick();
    check("w1c_irq_low", {31'h0, ctrl_irq}, 32'h0);
    bus_read(8'h04, d); check("w1c_pending", d, 32'h0);

    // Debounce on channel 1 falling edge with FILTER=10
    bus_write(8'h10, 32'd10);
    bus_write(8'h00, 32'h10);
    bus_write(8'h08, 32'h2);
    bus_write(8'h04, 32'hF);
    g = $urandom_range(1, 8);
    pins[1] = 1'b0;
    repeat (g) tick();
    pins[1] = 1'b1;
    repeat (20) tick();
    bus_read(8'h04, d); check("glitch_no_pend", d, 32'h0);
    bus_read(8'h0C, d); check("glitch_state", d, 32'hF);
    pins[1] = 1'b0;
    repeat (12) tick();
    ctrl_rd = 1'b1; ctrl_addr = 8'h0C;
    tick();
    check("state_before_flip", ctrl_rdat, 32'hF);
    ctrl_rd = 1'b0;
    tick();
    ctrl_rd = 1'b1;
    tick();
    check("state_after_flip", ctrl_rdat, 32'hD);
    ctrl_rd = 1'b0;
    tick();
    bus_read(8'h04, d); check("fe_pending", d, 32'h2);
    pins[1] = 1'b1;

    // Low-level trigger on channel 2 holds off W1C. ENABLE masks the irq.
    bus_write(8'h10, 32'h0);
    bus_write(8'h00, 32'h400);
    bus_write(8'h08, 32'h4);
    pins[2] = 1'b0;
    repeat (6) tick();
    bus_write(8'h04, 32'hF);
    bus_read(8'h04, d); check("lo_pending", d, 32'h4);
    check("lo_irq", {31'h0, ctrl_irq}, 32'h1);
    bus_write(8'h04, 32'h4);
    bus_read(8'h04, d); check("lo_w1c_resets", d, 32'h4);
    bus_write(8'h08, 32'h0);
    repeat (3) tick();
    check("masked_irq", {31'h0, ctrl_irq}, 32'h0);
    bus_read(8'h04, d); check("masked_pending", d, 32'h4);
    pins[2] = 1'b1;

    // Same-cycle falling-edge set and W1C on channel 3
    bus_write(8'h00, 32'h1000);
    bus_write(8'h08, 32'h8);
    repeat (4) tick();
    bus_write(8'h04, 32'hF);
    bus_read(8'h04, d); check("pre_collide_pending", d, 32'h0);
    pins[3] = 1'b0;
    repeat (3) tick();
    ctrl_wr = 1'b1; ctrl_addr = 8'h04; ctrl_wdat = 32'h8;
    tick();
    ctrl_wr = 1'b0;
    tick();
    bus_read(8'h04, d); check("set_beats_w1c", d, 32'h8);
    check("collide_irq", {31'h0, ctrl_irq}, 32'h1);
    ctrl_rd = 1'b1; ctrl_addr = 8'h20;
    tick();
    check("unmapped_rdat", ctrl_rdat, 32'h0);
    check("unmapped_done", {31'h0, ctrl_done}, 32'h1);
    ctrl_rd = 1'b0;
    tick();

    // Asynchronous reset in the middle of a read
    pins = '1;
    bus_write(8'h00, 32'h8888);
    bus_write(8'h08, 32'hF);
    repeat (6) tick();
    bus_read(8'h04, d); check("all_pending", d, 32'hF);
    ctrl_rd = 1'b1; ctrl_addr = 8'h04;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rdat", ctrl_rdat, 32'h0);
    check("async_done", {31'h0, ctrl_done}, 32'h0);
    check("async_irq", {31'h0, ctrl_irq}, 32'h0);
    repeat (3) tick();
    resetn = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (ctrl_done === 1'b1) pulses++;
    end
    check("held_rd_pulses", pulses, 5);
    ctrl_rd = 1'b0;
    tick();
    bus_read(8'h00, d); check("post_rst_config", d, 32'h0);
    bus_read(8'h04, d); check("post_rst_pending", d, 32'h0);
    bus_read(8'h08, d); check("post_rst_enable", d, 32'h0);
    bus_read(8'h10, d); check("post_rst_filter", d, 32'h0);

    // Randomised traffic checked cycle by cycle against the model
    for (int it = 0; it < 200; it++) begin
      logic [7:0] a;
      if ($urandom_range(0, 2) == 0) pins = pins ^ NP'(1 << $urandom_range(0, NP-1));
      case ($urandom_range(0, 3))
        0: tick();
        1: begin
          a = 8'($urandom_range(0, 5) * 4);
          if (a == 8'h10) bus_write(a, $urandom_range(0, 6));
          else            bus_write(a, $urandom);
        end
        2: begin
          a = ($urandom_range(0, 6) == 6) ? 8'h20 : 8'($urandom_range(0, 5) * 4);
          bus_read(a, d);
        end
        default: repeat ($urandom_range(1, 8)) tick();
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
